// File: rtl/vga_scanout_if.sv
// vga_scanout_if: colour-map lookup and VGA DAC signals between the raster generator and the SoC/DAC side.
interface vga_scanout_if;
  logic [9:0] DrawX, DrawY;
  logic [7:0] cm_r, cm_g, cm_b;
  logic pattern_sel;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start;
  modport master(
    output DrawX, DrawY, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start,
    input cm_r, cm_g, cm_b, pattern_sel
  );
  modport slave(
    input DrawX, DrawY, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start,
    output cm_r, cm_g, cm_b, pattern_sel
  );
endinterface

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 raster counters, colour-map lookup addressing and delay-matched VGA output stage.
// Optional colour-bar test pattern enabled by defining VGA_TEST_PATTERN_EN.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int LUT_LATENCY = 2
) (
  input logic Clk,
  input logic Reset,
  vga_scanout_if.master vga
);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
`ifdef VGA_TEST_PATTERN_EN
  localparam int W = 6;
`else
  localparam int W = 3;
`endif
  // delay-line word: {[bar,] hs, vs, active}; idle = syncs high, blanked
  localparam logic [W-1:0] IDLE = W'(3'b110);
  logic [9:0] hc, vc;
  logic raw_hs, raw_vs, raw_active;
  logic [W-1:0] raw, dl;
  logic [23:0] colour;
  always_ff @(posedge Clk)
    if (Reset) begin
      hc <= '0;
      vc <= '0;
    end else begin
      hc <= hc == H_LAST ? '0 : hc + 10'd1;
      vc <= hc != H_LAST ? vc : vc == V_LAST ? '0 : vc + 10'd1;
    end
  assign raw_hs = !(hc >= HS_BEG && hc < HS_END);
  assign raw_vs = !(vc >= VS_BEG && vc < VS_END);
  assign raw_active = hc < H_ACT && vc < V_ACT;
  assign vga.DrawX = hc;
  assign vga.DrawY = vc;
  assign vga.frame_start = !Reset && hc == '0 && vc == '0;
  assign vga.VGA_SYNC_N = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
  assign raw = {hc[9:7], raw_hs, raw_vs, raw_active};
  assign colour = vga.pattern_sel ? {{8{dl[3]}}, {8{dl[4]}}, {8{dl[5]}}} : {vga.cm_r, vga.cm_g, vga.cm_b};
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = vga.pattern_sel;
  assign raw = {raw_hs, raw_vs, raw_active};
  assign colour = {vga.cm_r, vga.cm_g, vga.cm_b};
`endif
  generate
    if (LUT_LATENCY == 0) begin : g_direct
      assign dl = raw;
    end else begin : g_pipe
      logic [W-1:0] pipe [LUT_LATENCY];
      always_ff @(posedge Clk) begin
        pipe[0] <= Reset ? IDLE : raw;
        for (int i = 1; i < LUT_LATENCY; i++) pipe[i] <= Reset ? IDLE : pipe[i-1];
      end
      assign dl = pipe[LUT_LATENCY-1];
    end
  endgenerate
  always_ff @(posedge Clk)
    if (Reset) begin
      vga.VGA_HS <= 1'b1;
      vga.VGA_VS <= 1'b1;
      vga.VGA_BLANK_N <= 1'b0;
      {vga.VGA_R, vga.VGA_G, vga.VGA_B} <= '0;
    end else begin
      vga.VGA_HS <= dl[2];
      vga.VGA_VS <= dl[1];
      vga.VGA_BLANK_N <= dl[0];
      {vga.VGA_R, vga.VGA_G, vga.VGA_B} <= dl[0] ? colour : '0;
    end
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: scoreboard bench for vga_scanout at LUT_LATENCY 0 and 2 with a shortened vertical frame.
module tb_vga_scanout;
  localparam int HT = 800;
  localparam int VA = 6, VF = 1, VSY = 2, VB = 2;
  localparam int VT = VA + VF + VSY + VB;
  typedef struct packed {logic hs; logic vs; logic act; logic [9:0] x; logic [9:0] y;} exp_t;
  localparam exp_t IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0, x: 10'd0, y: 10'd0};
  logic clk = 1'b0, rst = 1'b1, psel = 1'b0, run = 1'b0;
  int n_cmp = 0, n_bad = 0;
  always #20 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = 2 * g;
    vga_scanout_if bus();
    vga_scanout #(.V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .LUT_LATENCY(L)) dut (
      .Clk(clk), .Reset(rst), .vga(bus)
    );
    logic [19:0] hist [5];
    logic [19:0] cmxy;
    always @(posedge clk) begin
      hist[0] <= {bus.DrawX, bus.DrawY};
      for (int i = 1; i < 5; i++) hist[i] <= hist[i-1];
    end
    assign cmxy = L == 0 ? {bus.DrawX, bus.DrawY} : hist[L == 0 ? 0 : L - 1];
    assign bus.cm_r = cmxy[17:10];
    assign bus.cm_g = cmxy[7:0];
    assign bus.cm_b = 8'h5A;
    assign bus.pattern_sel = psel;
    int ex = 0, ey = 0, hs_run = 0, fs_gap = 0;
    logic psel_q = 1'b0, fs_ok = 1'b0;
    exp_t q[$];
    always @(posedge clk) begin
      psel_q = psel;
      if (rst) begin
        ex = 0;
        ey = 0;
        for (int i = 0; i < q.size(); i++) q[i] = IDLE;
      end else if (ex == HT - 1) begin
        ex = 0;
        ey = ey == VT - 1 ? 0 : ey + 1;
      end else ex++;
    end
    always @(negedge clk) if (run) begin : mon
      exp_t e, o;
      logic [23:0] rgb;
      check($sformatf("L%0d DrawX", L), 32'(bus.DrawX), ex);
      check($sformatf("L%0d DrawY", L), 32'(bus.DrawY), ey);
      check($sformatf("L%0d frame_start", L), 32'(bus.frame_start), 32'(ex == 0 && ey == 0 && !rst));
      check($sformatf("L%0d SYNC_N", L), 32'(bus.VGA_SYNC_N), 0);
      e.hs = !(ex >= 656 && ex < 752);
      e.vs = !(ey >= VA + VF && ey < VA + VF + VSY);
      e.act = ex < 640 && ey < VA;
      e.x = ex[9:0];
      e.y = ey[9:0];
      q.push_back(e);
      if (q.size() > L + 1) begin
        o = q.pop_front();
        rgb = o.act ? {o.x[7:0], o.y[7:0], 8'h5A} : 24'h0;
`ifdef VGA_TEST_PATTERN_EN
        if (o.act && psel_q) rgb = {{8{o.x[7]}}, {8{o.x[8]}}, {8{o.x[9]}}};
`endif
        check($sformatf("L%0d HS", L), 32'(bus.VGA_HS), 32'(o.hs));
        check($sformatf("L%0d VS", L), 32'(bus.VGA_VS), 32'(o.vs));
        check($sformatf("L%0d BLANK_N", L), 32'(bus.VGA_BLANK_N), 32'(o.act));
        check($sformatf("L%0d RGB x=%0d y=%0d", L, o.x, o.y), 32'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), 32'(rgb));
      end
      if (rst) hs_run = 0;
      else if (!bus.VGA_HS) hs_run++;
      else begin
        if (hs_run != 0) check($sformatf("L%0d HS width", L), hs_run, 96);
        hs_run = 0;
      end
      if (rst) fs_ok = 1'b0;
      if (bus.frame_start) begin
        if (fs_ok) check($sformatf("L%0d frame period", L), fs_gap, HT * VT);
        fs_gap = 0;
        fs_ok = 1'b1;
      end
      fs_gap++;
    end
  end
  initial begin
    int t;
    @(posedge clk);
    #1 run = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2 * HT * VT + 50) @(posedge clk);
    t = 0;
    do begin
      @(posedge clk);
      #1 t++;
    end while (!(g_dut[0].ex == 700 && g_dut[0].ey == 3) && t < 2 * HT * VT);
    check("reset point reached", 32'(t < 2 * HT * VT), 1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (HT * VT + 100) @(posedge clk);
    #1 psel = 1'b1;
    repeat (HT * VT + 100) @(posedge clk);
    #1 run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
